// File: rtl/xbar_ctrl_rr.sv
// Crossbar control for simple_mesh_xy: one staged flit per input, and a
// round-robin arbiter per output that holds the output for a whole packet.
//
// Ports:
//   clk_i, rst_ni   switch clock, async active-low reset
//   empty_i         input FIFO empty flags
//   rd_en_o         input FIFO pop (data lands in staging reg next cycle)
//   vld_input_o     staging reg i holds a valid flit
//   route_i         destination of staged flit i, slice [i*SEL_W +: SEL_W]
//   last_i          staged flit i is a packet tail
//   full_i          output FIFO full flags
//   wr_en_o         output FIFO push
//   sel_o           per-output input select, slice [o*SEL_W +: SEL_W]
//   err_o           sticky: a valid staged flit had an out-of-range route
module xbar_ctrl_rr #(
  parameter int PORT_N = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [PORT_N-1:0]         empty_i,
  output logic [PORT_N-1:0]         rd_en_o,
  output logic [PORT_N-1:0]         vld_input_o,
  input  logic [PORT_N*$clog2(PORT_N)-1:0] route_i,
  input  logic [PORT_N-1:0]         last_i,
  input  logic [PORT_N-1:0]         full_i,
  output logic [PORT_N-1:0]         wr_en_o,
  output logic [PORT_N*$clog2(PORT_N)-1:0] sel_o,
  output logic                      err_o
);

  localparam int SEL_W = $clog2(PORT_N);

  typedef logic [SEL_W-1:0] sel_t;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lock_e;

  logic [PORT_N-1:0] vld_q, vld_d;
  lock_e             lock_q  [PORT_N];
  lock_e             lock_d  [PORT_N];
  sel_t              owner_q [PORT_N];
  sel_t              owner_d [PORT_N];
  sel_t              ptr_q   [PORT_N];
  sel_t              ptr_d   [PORT_N];
  logic              err_q, err_d;

  sel_t              route   [PORT_N];
  logic [PORT_N-1:0] req     [PORT_N];
  sel_t              win     [PORT_N];
  logic [PORT_N-1:0] win_vld;
  logic [PORT_N-1:0] grant;
  logic [PORT_N-1:0] pop;
  logic [PORT_N-1:0] rd_en;

  always_comb begin
    for (int i = 0; i < PORT_N; i++) begin
      route[i] = route_i[i*SEL_W +: SEL_W];
    end
  end

  // req[o][i]: input i wants output o
  always_comb begin
    for (int o = 0; o < PORT_N; o++) begin
      for (int i = 0; i < PORT_N; i++) begin
        req[o][i] = vld_q[i] && (route[i] == sel_t'(o));
      end
    end
  end

  // Downward scan so the requester closest to ptr is written last and wins.
  always_comb begin
    sel_t idx;
    idx = '0;
    for (int o = 0; o < PORT_N; o++) begin
      win[o]     = '0;
      win_vld[o] = 1'b0;
      if (lock_q[o] == BUSY) begin
        win[o]     = owner_q[o];
        win_vld[o] = req[o][owner_q[o]];
      end else begin
        for (int k = PORT_N - 1; k >= 0; k--) begin
          idx = sel_t'((int'(ptr_q[o]) + k) % PORT_N);
          if (req[o][idx]) begin
            win[o]     = idx;
            win_vld[o] = 1'b1;
          end
        end
      end
    end
  end

  assign grant = win_vld & ~full_i;

  always_comb begin
    pop = '0;
    for (int o = 0; o < PORT_N; o++) begin
      for (int i = 0; i < PORT_N; i++) begin
        if (grant[o] && (win[o] == sel_t'(i))) pop[i] = 1'b1;
      end
    end
  end

  // Refill a slot in the same cycle it drains.
  assign rd_en = {PORT_N{rst_ni}} & ~empty_i & (~vld_q | pop);
  assign vld_d = rd_en | (vld_q & ~pop);

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < PORT_N; i++) begin
      if (vld_q[i] && (int'(route[i]) >= PORT_N)) err_d = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_N; o++) begin
      lock_d[o]  = lock_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (grant[o]) begin
        unique case (lock_q[o])
          IDLE: begin
            ptr_d[o] = (int'(win[o]) == PORT_N - 1) ?
                       '0 : win[o] + sel_t'(1);
            if (!last_i[win[o]]) begin
              lock_d[o]  = BUSY;
              owner_d[o] = win[o];
            end
          end
          BUSY: begin
            if (last_i[win[o]]) lock_d[o] = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      err_q <= 1'b0;
      for (int o = 0; o < PORT_N; o++) begin
        lock_q[o]  <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      for (int o = 0; o < PORT_N; o++) begin
        lock_q[o]  <= lock_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_N; o++) begin
      sel_o[o*SEL_W +: SEL_W] = win[o];
    end
  end

  assign wr_en_o     = grant;
  assign rd_en_o     = rd_en;
  assign vld_input_o = vld_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_xbar_ctrl_rr.sv
// Directed bench for xbar_ctrl_rr (PORT_N=5): each step drives inputs
// after a falling edge and checks against hand-computed values.
module tb_xbar_ctrl_rr;

  localparam int N = 5;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   empty_i, rd_en_o, vld_input_o;
  logic [N*W-1:0] route_i, sel_o;
  logic [N-1:0]   last_i, full_i, wr_en_o;
  logic           err_o;
  logic [W-1:0]   rt [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) route_i[i*W +: W] = rt[i];
  end

  xbar_ctrl_rr #(.PORT_N(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .empty_i    (empty_i),
    .rd_en_o    (rd_en_o),
    .vld_input_o(vld_input_o),
    .route_i    (route_i),
    .last_i     (last_i),
    .full_i     (full_i),
    .wr_en_o    (wr_en_o),
    .sel_o      (sel_o),
    .err_o      (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sel(input int o);
    return sel_o[o*W +: W];
  endfunction

  task automatic setrt(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [W-1:0] e);
    rt[0] = a; rt[1] = b; rt[2] = c; rt[3] = d; rt[4] = e;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    rst_ni  = 1'b0;
    empty_i = '0;
    last_i  = '1;
    full_i  = '0;
    setrt(0, 0, 0, 0, 0);

    // reset state with non-empty FIFOs
    step; #1;
    chk("rst_rd_en", 32'(rd_en_o), 0);
    chk("rst_wr_en", 32'(wr_en_o), 0);
    chk("rst_sel", 32'(sel_o), 0);
    chk("rst_vld", 32'(vld_input_o), 0);
    chk("rst_err", 32'(err_o), 0);

    step; rst_ni = 1'b1; #1;
    chk("rel_rd_en", 32'(rd_en_o), 32'h1f);

    // full permutation, bypass refill on input 0
    step;
    empty_i = 5'b11110;
    setrt(1, 2, 3, 4, 0);
    last_i = '1;
    #1;
    chk("perm_vld", 32'(vld_input_o), 32'h1f);
    chk("perm_wr_en", 32'(wr_en_o), 32'h1f);
    for (int o = 0; o < N; o++) begin
      chk($sformatf("perm_sel%0d", o), 32'(sel(o)), 32'((o + 4) % 5));
    end
    chk("perm_rd_en", 32'(rd_en_o), 32'h01);

    // inputs 0,2,3 contend for output 4, continuous refill
    step;
    empty_i = 5'b10010;
    setrt(4, 0, 4, 4, 0);
    #1;
    chk("rr_vld0", 32'(vld_input_o), 32'h01);
    chk("rr_rd_en0", 32'(rd_en_o), 32'h0d);
    chk("rr_wr0", 32'(wr_en_o), 32'h10);
    chk("rr_sel0", 32'(sel(4)), 0);
    step; #1;
    chk("rr_rd_en1", 32'(rd_en_o), 32'h04);
    chk("rr_wr1", 32'(wr_en_o), 32'h10);
    chk("rr_sel1", 32'(sel(4)), 2);
    step; #1;
    chk("rr_sel2", 32'(sel(4)), 3);
    step; #1;
    chk("rr_sel3", 32'(sel(4)), 0);
    step; #1;
    chk("rr_sel4", 32'(sel(4)), 2);
    step; #1;
    chk("rr_sel5", 32'(sel(4)), 3);
    chk("rr_wr5", 32'(wr_en_o), 32'h10);

    step; rst_ni = 1'b0; empty_i = '1;
    step; rst_ni = 1'b1;

    // 3-flit packet from input 1 holds output 2 against input 0
    step;
    empty_i = 5'b11101;
    setrt(2, 2, 0, 0, 0);
    last_i = 5'b00001;
    #1;
    chk("pkt_rd_en0", 32'(rd_en_o), 32'h02);
    chk("pkt_wr0", 32'(wr_en_o), 0);
    step; empty_i = 5'b11100; #1;
    chk("pkt_rd_en1", 32'(rd_en_o), 32'h03);
    chk("pkt_wr1", 32'(wr_en_o), 32'h04);
    chk("pkt_sel1", 32'(sel(2)), 1);
    step; #1;
    chk("pkt_vld2", 32'(vld_input_o), 32'h03);
    chk("pkt_rd_en2", 32'(rd_en_o), 32'h02);
    chk("pkt_sel2", 32'(sel(2)), 1);
    step; empty_i = '1; last_i = 5'b00011; #1;
    chk("pkt_wr3", 32'(wr_en_o), 32'h04);
    chk("pkt_sel3", 32'(sel(2)), 1);
    step; #1;
    chk("pkt_vld4", 32'(vld_input_o), 32'h01);
    chk("pkt_wr4", 32'(wr_en_o), 32'h04);
    chk("pkt_sel4", 32'(sel(2)), 0);

    // output 3 full for four cycles with input 2 pending
    step;
    empty_i = 5'b11011;
    setrt(0, 0, 3, 0, 0);
    last_i = '1;
    full_i = 5'b01000;
    #1;
    chk("full_rd_en0", 32'(rd_en_o), 32'h04);
    for (int c = 1; c <= 4; c++) begin
      step; #1;
      chk($sformatf("full_wr%0d", c), 32'(wr_en_o), 0);
      chk($sformatf("full_rd_en%0d", c), 32'(rd_en_o), 0);
    end
    step; full_i = '0; #1;
    chk("full_wr5", 32'(wr_en_o), 32'h08);
    chk("full_sel5", 32'(sel(3)), 2);
    chk("full_rd_en5", 32'(rd_en_o), 32'h04);
    step; empty_i = '1; #1;
    chk("full_wr6", 32'(wr_en_o), 32'h08);

    // bad route, sticky error, reset mid-packet
    step;
    empty_i = 5'b11011;
    setrt(0, 0, 7, 0, 0);
    #1;
    chk("err_rd_en0", 32'(rd_en_o), 32'h04);
    step; empty_i = '1; #1;
    chk("err_wr1", 32'(wr_en_o), 0);
    chk("err_early", 32'(err_o), 0);
    step; #1;
    chk("err_set", 32'(err_o), 1);
    chk("err_vld", 32'(vld_input_o), 32'h04);
    chk("err_wr2", 32'(wr_en_o), 0);
    step;
    empty_i = 5'b11010;
    setrt(1, 0, 1, 0, 0);
    last_i = 5'b00001;
    #1;
    chk("mid_wr0", 32'(wr_en_o), 32'h02);
    chk("mid_sel0", 32'(sel(1)), 2);
    chk("mid_rd_en0", 32'(rd_en_o), 32'h05);
    chk("err_sticky", 32'(err_o), 1);
    step; empty_i = '1; #1;
    chk("mid_vld1", 32'(vld_input_o), 32'h05);
    chk("mid_lock", 32'(sel(1)), 2);
    step; rst_ni = 1'b0; #1;
    chk("mid_rst_err", 32'(err_o), 0);
    chk("mid_rst_vld", 32'(vld_input_o), 0);
    chk("mid_rst_wr", 32'(wr_en_o), 0);
    step;
    rst_ni = 1'b1;
    empty_i = 5'b11010;
    last_i = '1;
    #1;
    chk("post_rd_en", 32'(rd_en_o), 32'h05);
    step; empty_i = '1; #1;
    chk("post_wr", 32'(wr_en_o), 32'h02);
    chk("post_unlock", 32'(sel(1)), 0);
    chk("post_err", 32'(err_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
